// File: rtl/ram_seq_pkg.sv
// rtl/ram_seq_pkg.sv - shared state type and constants for the MSX RAM sequencer
package ram_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_WR_REQ,
      ST_WR_WAIT,
      ST_RFSH,
      ST_HOLD
   } ram_seq_state_t;

   localparam int         TIMEOUT_DEFAULT = 255;
   localparam logic [7:0] ABORT_DATA      = 8'hFF;

   // States that hold the Z80 in wait and run the timeout counter.
   function automatic logic is_busy(input ram_seq_state_t s);
      return (s == ST_RD_REQ) || (s == ST_RD_WAIT) || (s == ST_WR_REQ);
   endfunction

endpackage

// File: rtl/ram_seq_cache.sv
// rtl/ram_seq_cache.sv - one-entry read cache (tag, data, valid), used with RAM_SEQ_READ_CACHE_EN
module ram_seq_cache #(
   parameter int ADDR_WIDTH = 23
) (
   input  logic                  CLK,
   input  logic                  RESET_n,
   input  logic [ADDR_WIDTH-1:0] lookup_addr,
   output logic                  hit,
   output logic [7:0]            hit_data,
   input  logic                  fill,
   input  logic [ADDR_WIDTH-1:0] fill_addr,
   input  logic [7:0]            fill_data,
   input  logic                  inval
);

   logic                  valid;
   logic [ADDR_WIDTH-1:0] tag;
   logic [7:0]            data;

   assign hit      = valid && (tag == lookup_addr);
   assign hit_data = data;

   // Invalidate wins over a same-cycle fill.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         valid <= 1'b0;
         tag   <= '0;
         data  <= '0;
      end else if (inval) begin
         valid <= 1'b0;
      end else if (fill) begin
         valid <= 1'b1;
         tag   <= fill_addr;
         data  <= fill_data;
      end
   end

endmodule

// File: rtl/msx_ram_sequencer.sv
// rtl/msx_ram_sequencer.sv - MSX strobe to memory req/ack sequencer; optional read cache via RAM_SEQ_READ_CACHE_EN
module msx_ram_sequencer
   import ram_seq_pkg::*;
#(
   parameter int ADDR_WIDTH = 23,
   parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
   input  logic                  CLK,
   input  logic                  RESET_n,
   input  logic [ADDR_WIDTH-1:0] H_ADDR,
   input  logic [7:0]            H_DIN,
   input  logic                  H_OE_n,
   input  logic                  H_WE_n,
   input  logic                  H_RFSH_n,
   output logic [7:0]            H_DOUT,
   output logic                  H_WAIT_n,
   output logic                  M_REQ,
   output logic                  M_WE,
   output logic [ADDR_WIDTH-1:0] M_ADDR,
   output logic [7:0]            M_WDATA,
   input  logic                  M_ACK,
   input  logic [7:0]            M_RDATA,
   input  logic                  M_RVALID,
   output logic                  M_RFSH_REQ,
   input  logic                  M_RFSH_ACK,
   output logic                  ERR
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   ram_seq_state_t state, next_state;
   logic           prev_oe_n, prev_we_n, prev_rfsh_n;
   logic           rfsh_pending;
   logic [7:0]     cnt;
   logic           oe_fall, we_fall, rfsh_fall, cnt_last;
   logic           abort, rd_done, hit_load;
   logic           cache_hit;
   logic [7:0]     cache_data;

   assign oe_fall   = prev_oe_n & ~H_OE_n;
   assign we_fall   = prev_we_n & ~H_WE_n;
   assign rfsh_fall = prev_rfsh_n & ~H_RFSH_n;
   assign cnt_last  = (cnt == TIMEOUT_LAST);

`ifdef RAM_SEQ_READ_CACHE_EN
   logic cache_inval;
   assign cache_inval = ((state == ST_IDLE) && we_fall) || abort;

   ram_seq_cache #(.ADDR_WIDTH(ADDR_WIDTH)) u_cache (
      .CLK         (CLK),
      .RESET_n     (RESET_n),
      .lookup_addr (H_ADDR),
      .hit         (cache_hit),
      .hit_data    (cache_data),
      .fill        (rd_done),
      .fill_addr   (M_ADDR),
      .fill_data   (M_RDATA),
      .inval       (cache_inval)
   );
`else
   assign cache_hit  = 1'b0;
   assign cache_data = 8'h00;
`endif

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) state <= ST_IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      abort      = 1'b0;
      rd_done    = 1'b0;
      hit_load   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (we_fall) begin
               next_state = ST_WR_REQ;
            end else if (oe_fall) begin
               if (cache_hit) begin
                  next_state = ST_HOLD;
                  hit_load   = 1'b1;
               end else begin
                  next_state = ST_RD_REQ;
               end
            end else if (rfsh_pending) begin
               next_state = ST_RFSH;
            end
         end
         // Memory may ack and return data in the same cycle.
         ST_RD_REQ: begin
            if (M_ACK && M_RVALID) begin
               next_state = ST_HOLD;
               rd_done    = 1'b1;
            end else if (M_ACK) begin
               next_state = ST_RD_WAIT;
            end else if (cnt_last) begin
               next_state = ST_HOLD;
               abort      = 1'b1;
            end
         end
         ST_RD_WAIT: begin
            if (M_RVALID) begin
               next_state = ST_HOLD;
               rd_done    = 1'b1;
            end else if (cnt_last) begin
               next_state = ST_HOLD;
               abort      = 1'b1;
            end
         end
         ST_WR_REQ: begin
            if (M_ACK) begin
               next_state = ST_WR_WAIT;
            end else if (cnt_last) begin
               next_state = ST_HOLD;
               abort      = 1'b1;
            end
         end
         ST_WR_WAIT: next_state = ST_HOLD;
         ST_RFSH:    if (M_RFSH_ACK) next_state = ST_IDLE;
         ST_HOLD:    if (H_OE_n && H_WE_n) next_state = ST_IDLE;
         default:    next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         prev_oe_n    <= 1'b1;
         prev_we_n    <= 1'b1;
         prev_rfsh_n  <= 1'b1;
         rfsh_pending <= 1'b0;
         cnt          <= '0;
         H_DOUT       <= '0;
         H_WAIT_n     <= 1'b1;
         M_REQ        <= 1'b0;
         M_WE         <= 1'b0;
         M_ADDR       <= '0;
         M_WDATA      <= '0;
         M_RFSH_REQ   <= 1'b0;
         ERR          <= 1'b0;
      end else begin
         prev_oe_n   <= H_OE_n;
         prev_we_n   <= H_WE_n;
         prev_rfsh_n <= H_RFSH_n;

         // A refresh edge while one is already pending is simply absorbed.
         if (M_RFSH_ACK)     rfsh_pending <= 1'b0;
         else if (rfsh_fall) rfsh_pending <= 1'b1;

         if (next_state != state || !is_busy(state)) cnt <= '0;
         else                                        cnt <= cnt + 8'd1;

         if (state == ST_IDLE && (we_fall || oe_fall)) M_ADDR <= H_ADDR;
         if (state == ST_IDLE && we_fall)              M_WDATA <= H_DIN;

         if (rd_done)                          H_DOUT <= M_RDATA;
         else if (abort && state != ST_WR_REQ) H_DOUT <= ABORT_DATA;
         else if (hit_load)                    H_DOUT <= cache_data;

         M_REQ      <= (next_state == ST_RD_REQ) || (next_state == ST_WR_REQ);
         M_WE       <= (next_state == ST_WR_REQ);
         M_RFSH_REQ <= (next_state == ST_RFSH);
         // Wait releases one cycle after read data lands or the write is accepted.
         H_WAIT_n   <= !(is_busy(next_state) || is_busy(state));
         if (abort) ERR <= 1'b1;
      end
   end

endmodule

// File: tb/tb_msx_ram_sequencer.sv
// tb/tb_msx_ram_sequencer.sv - directed self-checking bench for msx_ram_sequencer
module tb_msx_ram_sequencer;

   logic        CLK = 1'b0;
   logic        RESET_n;
   logic [22:0] H_ADDR;
   logic [7:0]  H_DIN;
   logic        H_OE_n, H_WE_n, H_RFSH_n;
   logic [7:0]  H_DOUT;
   logic        H_WAIT_n;
   logic        M_REQ, M_WE;
   logic [22:0] M_ADDR;
   logic [7:0]  M_WDATA;
   logic        M_ACK;
   logic [7:0]  M_RDATA;
   logic        M_RVALID;
   logic        M_RFSH_REQ;
   logic        M_RFSH_ACK;
   logic        ERR;

   int n_cmp = 0;
   int n_bad = 0;
   int req_rises = 0;
   int wait_low = 0;
   logic req_q = 1'b0;
   int req_cycles;
   int guard;

   msx_ram_sequencer dut (
      .CLK        (CLK),
      .RESET_n    (RESET_n),
      .H_ADDR     (H_ADDR),
      .H_DIN      (H_DIN),
      .H_OE_n     (H_OE_n),
      .H_WE_n     (H_WE_n),
      .H_RFSH_n   (H_RFSH_n),
      .H_DOUT     (H_DOUT),
      .H_WAIT_n   (H_WAIT_n),
      .M_REQ      (M_REQ),
      .M_WE       (M_WE),
      .M_ADDR     (M_ADDR),
      .M_WDATA    (M_WDATA),
      .M_ACK      (M_ACK),
      .M_RDATA    (M_RDATA),
      .M_RVALID   (M_RVALID),
      .M_RFSH_REQ (M_RFSH_REQ),
      .M_RFSH_ACK (M_RFSH_ACK),
      .ERR        (ERR)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (!H_WAIT_n) wait_low = wait_low + 1;
      if (M_REQ && !req_q) req_rises = req_rises + 1;
      req_q = M_REQ;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, " H_DOUT"},     32'(H_DOUT),     32'h0);
      chk({tag, " H_WAIT_n"},   32'(H_WAIT_n),   32'h1);
      chk({tag, " M_REQ"},      32'(M_REQ),      32'h0);
      chk({tag, " M_WE"},       32'(M_WE),       32'h0);
      chk({tag, " M_ADDR"},     32'(M_ADDR),     32'h0);
      chk({tag, " M_WDATA"},    32'(M_WDATA),    32'h0);
      chk({tag, " M_RFSH_REQ"}, 32'(M_RFSH_REQ), 32'h0);
      chk({tag, " ERR"},        32'(ERR),        32'h0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET_n = 1'b0; H_ADDR = '0; H_DIN = '0;
      H_OE_n = 1'b1; H_WE_n = 1'b1; H_RFSH_n = 1'b1;
      M_ACK = 1'b0; M_RDATA = '0; M_RVALID = 1'b0; M_RFSH_ACK = 1'b0;
      tick(); tick();
      chk_reset_values("reset");
      RESET_n = 1'b1;
      tick(); tick();

      // Read: ack on the second request cycle, data one cycle later.
      req_rises = 0; wait_low = 0;
      H_ADDR = 23'h012345; H_OE_n = 1'b0;
      tick();
      chk("rd req",  32'(M_REQ),  32'h1);
      chk("rd we",   32'(M_WE),   32'h0);
      chk("rd addr", 32'(M_ADDR), 32'h012345);
      chk("rd wait", 32'(H_WAIT_n), 32'h0);
      tick();
      M_ACK = 1'b1;
      tick();
      M_ACK = 1'b0; M_RVALID = 1'b1; M_RDATA = 8'hA5;
      chk("rd req drop", 32'(M_REQ), 32'h0);
      tick();
      M_RVALID = 1'b0; M_RDATA = 8'h00;
      chk("rd dout", 32'(H_DOUT), 32'hA5);
      tick();
      chk("rd wait release", 32'(H_WAIT_n), 32'h1);
      H_OE_n = 1'b1;
      tick(); tick();
      chk("rd one req",   32'(req_rises), 32'd1);
      chk("rd wait cycles", 32'(wait_low), 32'd4);

      // Write held low for 10 cycles: one request only.
      req_rises = 0; wait_low = 0;
      H_ADDR = 23'h000200; H_DIN = 8'h3C; H_WE_n = 1'b0;
      tick();
      chk("wr req",   32'(M_REQ),   32'h1);
      chk("wr we",    32'(M_WE),    32'h1);
      chk("wr wdata", 32'(M_WDATA), 32'h3C);
      chk("wr addr",  32'(M_ADDR),  32'h000200);
      M_ACK = 1'b1;
      repeat (9) begin
         tick();
         M_ACK = 1'b0;
      end
      chk("wr req idle",  32'(M_REQ),     32'h0);
      chk("wr one req",   32'(req_rises), 32'd1);
      chk("wr wait cycles", 32'(wait_low), 32'd2);
      H_WE_n = 1'b1;
      tick(); tick();

      // Refresh edge together with a read edge: read first, refresh after IDLE.
      req_rises = 0; wait_low = 0;
      H_ADDR = 23'h000300; H_OE_n = 1'b0; H_RFSH_n = 1'b0;
      tick();
      chk("rf read first", 32'(M_REQ),      32'h1);
      chk("rf not yet",    32'(M_RFSH_REQ), 32'h0);
      M_ACK = 1'b1; M_RVALID = 1'b1; M_RDATA = 8'h5A;
      tick();
      M_ACK = 1'b0; M_RVALID = 1'b0;
      chk("rf fast dout", 32'(H_DOUT), 32'h5A);
      H_OE_n = 1'b1; H_RFSH_n = 1'b1;
      tick();
      chk("rf idle no req", 32'(M_RFSH_REQ), 32'h0);
      tick();
      chk("rf req", 32'(M_RFSH_REQ), 32'h1);
      M_RFSH_ACK = 1'b1;
      tick();
      M_RFSH_ACK = 1'b0;
      chk("rf req drop", 32'(M_RFSH_REQ), 32'h0);
      tick();
      chk("rf no repeat", 32'(M_RFSH_REQ), 32'h0);
      chk("rf wait cycles", 32'(wait_low), 32'd2);

      // Both strobes fall together: write wins.
      req_rises = 0;
      H_ADDR = 23'h000350; H_DIN = 8'h99; H_OE_n = 1'b0; H_WE_n = 1'b0;
      tick();
      chk("both we", 32'(M_WE), 32'h1);
      M_ACK = 1'b1;
      tick();
      M_ACK = 1'b0;
      H_OE_n = 1'b1; H_WE_n = 1'b1;
      tick(); tick(); tick();
      chk("both one req", 32'(req_rises), 32'd1);

      // Read timeout: no ack ever.
      H_ADDR = 23'h000400; H_OE_n = 1'b0;
      tick();
      req_cycles = 0; guard = 0;
      while (M_REQ && guard < 400) begin
         req_cycles++;
         guard++;
         tick();
      end
      chk("to req cycles", 32'(req_cycles), 32'd255);
      chk("to dout",       32'(H_DOUT),     32'hFF);
      chk("to err",        32'(ERR),        32'h1);
      tick();
      chk("to wait release", 32'(H_WAIT_n), 32'h1);
      H_OE_n = 1'b1;
      tick(); tick();

      // Reset during RD_WAIT, then a fresh read.
      H_ADDR = 23'h000500; H_OE_n = 1'b0;
      tick();
      M_ACK = 1'b1;
      tick();
      M_ACK = 1'b0;
      RESET_n = 1'b0; H_OE_n = 1'b1;
      tick();
      chk_reset_values("midrd");
      RESET_n = 1'b1;
      tick(); tick();
      H_ADDR = 23'h000600; H_OE_n = 1'b0;
      tick();
      chk("post rst req",  32'(M_REQ),  32'h1);
      chk("post rst addr", 32'(M_ADDR), 32'h000600);
      M_ACK = 1'b1; M_RVALID = 1'b1; M_RDATA = 8'h77;
      tick();
      M_ACK = 1'b0; M_RVALID = 1'b0;
      chk("post rst dout", 32'(H_DOUT), 32'h77);
      H_OE_n = 1'b1;
      tick(); tick();

`ifdef RAM_SEQ_READ_CACHE_EN
      H_ADDR = 23'h000100; H_OE_n = 1'b0;
      tick();
      M_ACK = 1'b1; M_RVALID = 1'b1; M_RDATA = 8'h42;
      tick();
      M_ACK = 1'b0; M_RVALID = 1'b0;
      H_OE_n = 1'b1;
      tick(); tick();
      req_rises = 0; wait_low = 0;
      H_OE_n = 1'b0;
      tick();
      chk("cache hit dout",  32'(H_DOUT), 32'h42);
      chk("cache hit noreq", 32'(M_REQ),  32'h0);
      H_OE_n = 1'b1;
      tick(); tick();
      chk("cache hit wait", 32'(wait_low), 32'd0);
      H_WE_n = 1'b0; H_DIN = 8'h11;
      tick();
      M_ACK = 1'b1;
      tick();
      M_ACK = 1'b0; H_WE_n = 1'b1;
      tick(); tick();
      H_OE_n = 1'b0;
      tick();
      chk("cache inval req", 32'(M_REQ), 32'h1);
      M_ACK = 1'b1; M_RVALID = 1'b1; M_RDATA = 8'h11;
      tick();
      M_ACK = 1'b0; M_RVALID = 1'b0; H_OE_n = 1'b1;
      tick(); tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
